// File: rtl/brisc_pkg.sv
// Core-wide constants shared by the fetch/decode blocks.
package brisc_pkg;
  localparam int REG_LEN = 32;
  localparam logic [REG_LEN-1:0] PC_BOOT = '0;
endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake bundle: enqueue side (in_*) and dequeue side (out_*).
interface fetch_buffer_if #(
  parameter int PW = brisc_pkg::REG_LEN,
  parameter int IW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_pc;
  logic [IW-1:0] in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_pc;
  logic [IW-1:0] out_instr;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/fetch_buffer.sv
// In-order {pc, instr} queue between fetch and decode; flush empties it.
// Latency 1 cycle push-to-head; FETCH_BUF_BYPASS_EN adds a 0-cycle path when empty.
// in_ready = !full (no pass-through when full); fetch_enable drops SLACK entries early.
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int SLACK = 1,
  parameter int ILEN  = 32,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  fetch_buffer_if.slave  fb,
  output logic           fetch_enable,
  output logic [CW-1:0]  count
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [brisc_pkg::REG_LEN-1:0] pc;
    logic [ILEN-1:0]               instr;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rd_en;

  always_comb begin
    full         = (count == CW'(DEPTH));
    empty        = (count == '0);
    head         = mem[rd_ptr];
    fb.in_ready  = !full;
    fb.out_valid = !empty;
    fb.out_pc    = head.pc;
    fb.out_instr = head.instr;
    wr_en        = fb.in_valid && !full;
    rd_en        = !empty && fb.out_ready;
`ifdef FETCH_BUF_BYPASS_EN
    // Empty queue: present the incoming word directly; skip the write if decode takes it.
    if (empty && fb.in_valid && !flush && !rst) begin
      fb.out_valid = 1'b1;
      fb.out_pc    = fb.in_pc;
      fb.out_instr = fb.in_instr;
      if (fb.out_ready) wr_en = 1'b0;
    end
`endif
    fetch_enable = flush || (count < CW'(DEPTH - SLACK));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Any push this cycle is wrong-path; a pop this cycle was already taken by decode.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= '{pc: fb.in_pc, instr: fb.in_instr};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed vector bench for fetch_buffer (DEPTH=4, SLACK=1); build with or without FETCH_BUF_BYPASS_EN.
module tb_fetch_buffer;
  localparam int DEPTH = 4;
  localparam int SLACK = 1;
  localparam int ILEN  = 32;
  localparam int PW    = brisc_pkg::REG_LEN;
`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       fe;
  logic [2:0] count;
  int         checks = 0;
  int         errors = 0;

  fetch_buffer_if #(.PW(PW), .IW(ILEN)) fb();

  fetch_buffer #(.DEPTH(DEPTH), .SLACK(SLACK), .ILEN(ILEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .fb           (fb.slave),
    .fetch_enable (fe),
    .count        (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        ov;
    logic [31:0] opc;
    logic        ir;
    logic        fe;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl [20];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0F0F;
  endfunction

  function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic ordy,
                              input logic ov, input logic [31:0] opc, input logic ir,
                              input logic fe_e, input logic [2:0] cnt);
    vec_t v;
    v.iv = iv; v.pc = pc; v.ordy = ordy; v.ov = ov;
    v.opc = opc; v.ir = ir; v.fe = fe_e; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                       input logic ordy);
    rst         = r;
    flush       = f;
    fb.in_valid = iv;
    fb.in_pc    = pc;
    fb.in_instr = instr_of(pc);
    fb.out_ready = ordy;
  endtask

  // Inputs are applied 1 time unit after a rising edge; checks land just before the next one.
  task automatic settle();
    #8;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string nm, input logic [31:0] pc);
    chk({nm, " out_valid"}, 32'(fb.out_valid), 32'h1);
    chk({nm, " out_pc"}, fb.out_pc, pc);
    chk({nm, " out_instr"}, fb.out_instr, instr_of(pc));
  endtask

  initial begin
    logic        byp_row;
    logic [31:0] exp_pc;

    tbl[0]  = mk(1, 32'h00, 0, 0, 32'h00, 1, 1, 0);
    tbl[1]  = mk(1, 32'h04, 0, 1, 32'h00, 1, 1, 1);
    tbl[2]  = mk(1, 32'h08, 0, 1, 32'h00, 1, 1, 2);
    tbl[3]  = mk(1, 32'h0C, 0, 1, 32'h00, 1, 0, 3);
    tbl[4]  = mk(1, 32'h10, 0, 1, 32'h00, 0, 0, 4);
    tbl[5]  = mk(0, 32'h00, 1, 1, 32'h00, 0, 0, 4);
    tbl[6]  = mk(0, 32'h00, 1, 1, 32'h04, 1, 0, 3);
    tbl[7]  = mk(0, 32'h00, 1, 1, 32'h08, 1, 1, 2);
    tbl[8]  = mk(0, 32'h00, 1, 1, 32'h0C, 1, 1, 1);
    tbl[9]  = mk(0, 32'h00, 0, 0, 32'h00, 1, 1, 0);
    tbl[10] = mk(1, 32'h20, 0, 0, 32'h00, 1, 1, 0);
    tbl[11] = mk(1, 32'h24, 0, 1, 32'h20, 1, 1, 1);
    tbl[12] = mk(1, 32'h28, 0, 1, 32'h20, 1, 1, 2);
    tbl[13] = mk(1, 32'h2C, 0, 1, 32'h20, 1, 0, 3);
    tbl[14] = mk(1, 32'h30, 1, 1, 32'h20, 0, 0, 4);
    tbl[15] = mk(0, 32'h00, 0, 1, 32'h24, 1, 0, 3);
    tbl[16] = mk(0, 32'h00, 1, 1, 32'h24, 1, 0, 3);
    tbl[17] = mk(0, 32'h00, 1, 1, 32'h28, 1, 1, 2);
    tbl[18] = mk(0, 32'h00, 1, 1, 32'h2C, 1, 1, 1);
    tbl[19] = mk(0, 32'h00, 0, 0, 32'h00, 1, 1, 0);

    // Reset held two cycles with in_valid high.
    drive(1, 0, 1, 32'h50, 0);
    next_cycle();
    drive(1, 0, 1, 32'h50, 0);
    settle();
    chk("rst count", 32'(count), 32'h0);
    chk("rst out_valid", 32'(fb.out_valid), 32'h0);
    chk("rst out_pc", fb.out_pc, 32'h0);
    chk("rst out_instr", fb.out_instr, 32'h0);
    chk("rst in_ready", 32'(fb.in_ready), 32'h1);
    chk("rst fetch_enable", 32'(fe), 32'h1);
    next_cycle();

    // Fill/drain, full-with-pop refusal, drain after wrap.
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, tbl[i].iv, tbl[i].pc, tbl[i].ordy);
      settle();
      byp_row = BYP && (tbl[i].cnt == 3'd0) && tbl[i].iv;
      exp_pc  = byp_row ? tbl[i].pc : tbl[i].opc;
      chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d in_ready", i), 32'(fb.in_ready), 32'(tbl[i].ir));
      chk($sformatf("vec%0d fetch_enable", i), 32'(fe), 32'(tbl[i].fe));
      chk($sformatf("vec%0d out_valid", i), 32'(fb.out_valid), 32'(tbl[i].ov | byp_row));
      if (tbl[i].ov | byp_row) begin
        chk($sformatf("vec%0d out_pc", i), fb.out_pc, exp_pc);
        chk($sformatf("vec%0d out_instr", i), fb.out_instr, instr_of(exp_pc));
      end
      next_cycle();
    end

    // Steady push+pop: occupancy stays 1 while PCs 0x0..0x24 stream through.
    drive(0, 0, 1, 32'h0, 0);
    settle();
    chk("wrap k0 count", 32'(count), 32'h0);
    next_cycle();
    for (int k = 1; k < 10; k++) begin
      drive(0, 0, 1, 32'(4 * k), 1);
      settle();
      chk($sformatf("wrap k%0d count", k), 32'(count), 32'h1);
      chk_head($sformatf("wrap k%0d", k), 32'(4 * (k - 1)));
      next_cycle();
    end
    drive(0, 0, 0, 32'h0, 1);
    settle();
    chk("wrap tail count", 32'(count), 32'h1);
    chk_head("wrap tail", 32'h24);
    next_cycle();
    drive(0, 0, 0, 32'h0, 0);
    settle();
    chk("wrap empty count", 32'(count), 32'h0);
    chk("wrap empty out_valid", 32'(fb.out_valid), 32'h0);
    next_cycle();

    // Flush with three entries held and a push in the flush cycle.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 32'h60 + 32'(4 * k), 0);
      next_cycle();
    end
    drive(0, 1, 1, 32'h100, 0);
    settle();
    chk("flush pre count", 32'(count), 32'h3);
    chk("flush fetch_enable", 32'(fe), 32'h1);
    next_cycle();
    drive(0, 0, 0, 32'h0, 0);
    settle();
    chk("flush post count", 32'(count), 32'h0);
    chk("flush post out_valid", 32'(fb.out_valid), 32'h0);
    next_cycle();
    drive(0, 0, 1, 32'h70, 0);
    next_cycle();
    drive(0, 0, 0, 32'h0, 1);
    settle();
    chk("flush refill count", 32'(count), 32'h1);
    chk_head("flush refill", 32'h70);
    next_cycle();

    // Push into empty queue with decode ready.
    drive(0, 0, 1, 32'h40, 1);
    settle();
    chk("byp same out_valid", 32'(fb.out_valid), 32'(BYP));
    if (BYP) chk("byp same out_pc", fb.out_pc, 32'h40);
    next_cycle();
    drive(0, 0, 0, 32'h0, 0);
    settle();
    chk("byp next count", 32'(count), BYP ? 32'h0 : 32'h1);
    chk("byp next out_valid", 32'(fb.out_valid), BYP ? 32'h0 : 32'h1);
    if (!BYP) chk("byp next out_pc", fb.out_pc, 32'h40);
    drive(0, 0, 0, 32'h0, 1);
    next_cycle();

    // Reset mid-operation discards contents.
    drive(0, 0, 1, 32'h80, 0);
    next_cycle();
    drive(0, 0, 1, 32'h84, 0);
    next_cycle();
    drive(1, 0, 1, 32'h88, 1);
    next_cycle();
    drive(0, 0, 0, 32'h0, 0);
    settle();
    chk("midrst count", 32'(count), 32'h0);
    chk("midrst out_valid", 32'(fb.out_valid), 32'h0);
    chk("midrst out_pc", fb.out_pc, 32'h0);
    chk("midrst in_ready", 32'(fb.in_ready), 32'h1);
    chk("midrst fetch_enable", 32'(fe), 32'h1);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Decoupling queue between the instruction fetch stage and decode. Holds {pc, instr} pairs returned by instruction memory and presents them in order to decode through a valid/ready handshake.
- Drives the fetch-stage PC-advance enable to throttle fetch before the queue overflows.
- Empties on a branch redirect (flush) so that no wrong-path instruction reaches decode.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- SLACK, 1, number of entries kept free for fetches already in flight when fetch_enable drops; 0 <= SLACK < DEPTH.
- ILEN, 32, instruction word width.
- REG_LEN and PC_BOOT come from brisc_pkg (PC width and boot address).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  branch redirect; same signal as b_taken to the fetch stage.
- in_valid  in  1  fetched instruction available.
- in_pc  in  REG_LEN  PC of the fetched instruction.
- in_instr  in  ILEN  fetched instruction word.
- in_ready  out  1  queue can accept; equals !full.
- out_valid  out  1  head entry valid for decode.
- out_pc  out  REG_LEN  PC of the head entry.
- out_instr  out  ILEN  instruction word of the head entry.
- out_ready  in  1  decode accepts the head this cycle.
- fetch_enable  out  1  enable to the fetch-stage PC register.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage is a circular buffer with wr_ptr, rd_ptr and count registers. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- out_valid = (count != 0). out_pc and out_instr are read from mem[rd_ptr] and are registered-storage outputs: a push into an empty queue becomes visible on the next cycle (1-cycle latency, no bypass by default).
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, in_ready = 0 even if out_ready = 1 (no same-cycle pass-through).
- Push when full is impossible by handshake. If in_valid is asserted while full, the data is dropped and the upstream block must hold it.
- fetch_enable = flush || (count < DEPTH - SLACK). It is combinational from registered count and flush. flush forces it to 1 so the fetch stage loads the branch target.
- Flush, at the next edge:
  - count = 0 and wr_ptr = rd_ptr = 0.
  - A push presented in the flush cycle is discarded.
  - A pop handshake in the flush cycle still counts as consumed by decode.
- rst, at the next edge: count = 0, pointers = 0 and all mem entries = 0. Resulting outputs: out_valid = 0, out_pc = 0, out_instr = 0, in_ready = 1, fetch_enable = 1. rst overrides flush and any handshake. Reset mid-operation discards all contents.
- Priority: rst > flush > push/pop.
- Storage contents are never read while count = 0.

Optional Feature:
- Macro: FETCH_BUF_BYPASS_EN.
- Defined: when count = 0, in_valid = 1 and flush = 0:
  - out_valid = 1 combinationally, and out_pc/out_instr are taken from in_pc/in_instr.
  - If out_ready = 1 in that cycle, the entry is consumed without being written (count stays 0).
  - If out_ready = 0, it is written normally.
- Not defined: the 1-cycle latency described above; no combinational path from in_* to out_*.

Test Plan:
- Reset: assert rst 2 cycles with in_valid = 1 -> count = 0, out_valid = 0, out_pc = 0, in_ready = 1, fetch_enable = 1.
- Fill and drain, DEPTH = 4, SLACK = 1, out_ready = 0, push PC 0x0,0x4,0x8,0xC:
  - fetch_enable drops to 0 once count = 3; in_ready = 0 at count = 4.
  - Then out_ready = 1 -> 0x0,0x4,0x8,0xC pop in order on 4 consecutive cycles.
- Wrap-around: 10 push/pop pairs with a steady push+pop every cycle after the first push -> count stays 1, PCs 0x0..0x24 emerge in order, pointers wrap twice.
- Flush: 3 entries held, flush = 1 with in_valid = 1 (PC 0x100) -> fetch_enable = 1 that cycle; next cycle count = 0, out_valid = 0, PC 0x100 never appears.
- Simultaneous push/pop when full: count = 4, in_valid = 1, out_ready = 1 -> pop occurs, push refused (in_ready = 0), count = 3.
- Bypass, only with FETCH_BUF_BYPASS_EN: empty, in_valid = 1 with PC 0x40, out_ready = 1 -> same cycle out_valid = 1 and out_pc = 0x40; next cycle count = 0. Without the macro: out_valid first asserts on the next cycle.
